// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b cache geometry types and the two-state stream
//               engine encoding reused by word-streaming blocks.
//               lc3b_block : 128-bit cache line (eight words)
//               lc3b_word  : 16-bit word
//               lc3b_index : 3-bit word position within a line
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  typedef logic [127:0] lc3b_block;
  typedef logic [15:0]  lc3b_word;
  typedef logic [2:0]   lc3b_index;

  // IDLE: ready for a new line; STREAM: emitting beats of a captured line.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } lc3b_stream_state;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/blockwordselect.sv
`default_nettype none
// ============================================================================
// Module      : blockwordselect
// Description : Combinational 8:1 word mux; returns word `sel` of a line.
//               Read-side inverse of the word-into-line merge.
// Ports       : block (in)  - 128-bit line, word i at [16*i+15:16*i]
//               sel   (in)  - word index 0..7
//               word  (out) - selected 16-bit word
// Revision    : 1.0 - initial release
// ============================================================================
module blockwordselect
  import lc3b_types::*;
(
  input  lc3b_block block,
  input  lc3b_index sel,
  output lc3b_word  word
);

  always_comb begin
    word = 16'h0000;
    case (sel)
      3'd0: word = block[15:0];
      3'd1: word = block[31:16];
      3'd2: word = block[47:32];
      3'd3: word = block[63:48];
      3'd4: word = block[79:64];
      3'd5: word = block[95:80];
      3'd6: word = block[111:96];
      3'd7: word = block[127:112];
      default: word = 16'h0000;
    endcase
  end

endmodule : blockwordselect
`default_nettype wire

// File: rtl/block_word_streamer.sv
`default_nettype none
// ============================================================================
// Module      : block_word_streamer
// Description : Captures one 128-bit line and streams it as eight 16-bit
//               beats over valid/ready, critical word first, wrapping mod 8.
// Ports       : clk         (in)  - clock, rising edge
//               rst_n       (in)  - synchronous active-low reset
//               load        (in)  - capture block/start_index when in_ready
//               block       (in)  - line to stream
//               start_index (in)  - index of the first beat
//               flush       (in)  - abort the current burst
//               out_ready   (in)  - consumer accepts the current beat
//               in_ready    (out) - idle, a load will be accepted
//               word_valid  (out) - word/word_index/last are valid
//               word        (out) - current beat
//               word_index  (out) - line position of the current beat
//               last        (out) - current beat is the eighth of the burst
// Revision    : 1.0 - initial release
// ============================================================================
module block_word_streamer
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  lc3b_block block,
  input  lc3b_index start_index,
  input  logic      flush,
  input  logic      out_ready,
  output logic      in_ready,
  output logic      word_valid,
  output lc3b_word  word,
  output lc3b_index word_index,
  output logic      last
);

  localparam logic [2:0] c_last_count = 3'd7;

  lc3b_stream_state r_state, w_state_next;
  lc3b_block        r_line,  w_line_next;
  lc3b_index        r_idx,   w_idx_next;
  logic [2:0]       r_count, w_count_next;

  // Next-state / counter update. The line register only changes on an
  // accepted load, so a load during STREAM cannot corrupt the burst.
  always_comb begin
    w_state_next = r_state;
    w_line_next  = r_line;
    w_idx_next   = r_idx;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        // load takes precedence over a coincident flush (flush is a no-op here)
        if (load) begin
          w_state_next = STREAM;
          w_line_next  = block;
          w_idx_next   = start_index;
          w_count_next = 3'd0;
        end
      end
      STREAM: begin
        // flush wins over a same-cycle transfer; that beat is not delivered
        if (flush) begin
          w_state_next = IDLE;
        end else if (out_ready) begin
          w_idx_next   = r_idx + 3'd1;
          w_count_next = r_count + 3'd1;
          if (r_count == c_last_count) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_idx   <= 3'd0;
      r_count <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_line  <= w_line_next;
      r_idx   <= w_idx_next;
      r_count <= w_count_next;
    end
  end

  // Outputs depend only on registered state.
  assign in_ready   = (r_state == IDLE);
  assign word_valid = (r_state == STREAM);
  assign last       = word_valid && (r_count == c_last_count);
  assign word_index = r_idx;

  blockwordselect u_select (
    .block (r_line),
    .sel   (r_idx),
    .word  (word)
  );

endmodule : block_word_streamer
`default_nettype wire

// File: tb/tb_block_word_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_word_streamer
// Description : Self-checking bench for block_word_streamer. Expected beats
//               come from a line/start-index reference: beat k of a burst is
//               word (start+k) mod 8 of the loaded line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_word_streamer;

  localparam logic [127:0] c_b = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [127:0] block;
  logic [2:0]   start_index;
  logic         flush;
  logic         out_ready;
  logic         in_ready;
  logic         word_valid;
  logic [15:0]  word;
  logic [2:0]   word_index;
  logic         last;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  block_word_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .block       (block),
    .start_index (start_index),
    .flush       (flush),
    .out_ready   (out_ready),
    .in_ready    (in_ready),
    .word_valid  (word_valid),
    .word        (word),
    .word_index  (word_index),
    .last        (last)
  );

  // Reference: word at line position p.
  function automatic logic [15:0] ref_word(input logic [127:0] b, input int p);
    logic [127:0] sh;
    sh = b >> (16 * (p % 8));
    return sh[15:0];
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load for one edge; on return the first beat is showing.
  task automatic do_load(input logic [127:0] b, input logic [2:0] s);
    load = 1'b1; block = b; start_index = s;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++;
    if (in_ready !== 1'b1 || word_valid !== 1'b0 || last !== 1'b0 ||
        word_index !== 3'd0 || word !== 16'h0000) begin
      fails++;
      $display("FAIL reset: got rdy=%b vld=%b last=%b idx=%0d word=%h, want 1 0 0 0 0000",
               in_ready, word_valid, last, word_index, word);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    out_ready = 1'b1;
    do_load(c_b, 3'd0);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (word_valid !== 1'b1 || word !== ref_word(c_b, k) ||
          word_index !== 3'(k) || last !== (k == 7)) begin
        fails++;
        $display("FAIL aligned beat %0d: got vld=%b word=%h idx=%0d last=%b, want 1 %h %0d %b",
                 k, word_valid, word, word_index, last, ref_word(c_b, k), k, (k == 7));
      end
      tick();
    end
    tests++;
    if (in_ready !== 1'b1 || word_valid !== 1'b0) begin
      fails++;
      $display("FAIL aligned end: got rdy=%b vld=%b, want 1 0", in_ready, word_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    do_load(c_b, 3'd5);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (word_valid !== 1'b1 || word !== ref_word(c_b, 5 + k) ||
          word_index !== 3'((5 + k) % 8) || last !== (k == 7)) begin
        fails++;
        $display("FAIL wrap beat %0d: got vld=%b word=%h idx=%0d last=%b, want 1 %h %0d %b",
                 k, word_valid, word, word_index, last, ref_word(c_b, 5 + k), (5 + k) % 8, (k == 7));
      end
      tick();
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL wrap end: got rdy=%b, want 1", in_ready);
    end
  endtask

  task automatic test_backpressure();
    int e = 0, cycles = 0, hold = 0;
    out_ready = 1'b1;
    do_load(c_b, 3'd0);
    while (word_valid === 1'b1 && cycles < 30) begin
      tests++;
      if (word !== ref_word(c_b, e) || word_index !== 3'(e) || last !== (e == 7)) begin
        fails++;
        $display("FAIL backpressure cyc %0d: got word=%h idx=%0d last=%b, want %h %0d %b",
                 cycles, word, word_index, last, ref_word(c_b, e), e, (e == 7));
      end
      if (e == 2 && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      cycles++;
      tick();
      if (out_ready) e++;
    end
    out_ready = 1'b1;
    tests++;
    if (cycles !== 11 || e !== 8) begin
      fails++;
      $display("FAIL backpressure length: got %0d cycles %0d beats, want 11 8", cycles, e);
    end
  endtask

  task automatic test_load_busy();
    out_ready = 1'b1;
    do_load(c_b, 3'd0);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (word_valid !== 1'b1 || word !== ref_word(c_b, k) || word_index !== 3'(k)) begin
        fails++;
        $display("FAIL load_busy beat %0d: got vld=%b word=%h idx=%0d, want 1 %h %0d",
                 k, word_valid, word, word_index, ref_word(c_b, k), k);
      end
      if (k == 2) begin
        load = 1'b1; block = '1; start_index = 3'd6;
      end else begin
        load = 1'b0; block = c_b;
      end
      tick();
    end
    load = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || word_valid !== 1'b0) begin
      fails++;
      $display("FAIL load_busy end: got rdy=%b vld=%b, want 1 0", in_ready, word_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    do_load(c_b, 3'd0);
    tick(); tick(); tick();            // now on beat 3
    tests++;
    if (word !== 16'h3333 || word_index !== 3'd3) begin
      fails++;
      $display("FAIL flush pre: got word=%h idx=%0d, want 3333 3", word, word_index);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if (word_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush idle: got vld=%b rdy=%b, want 0 1", word_valid, in_ready);
    end
    // flush alone in IDLE is a no-op
    flush = 1'b1;
    tick();
    tests++;
    if (word_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush in idle: got vld=%b rdy=%b, want 0 1", word_valid, in_ready);
    end
    // flush+load in IDLE: load wins
    do_load(c_b, 3'd0);
    flush = 1'b0;
    tests++;
    if (word_valid !== 1'b1 || word !== 16'h0000 || word_index !== 3'd0) begin
      fails++;
      $display("FAIL flush restart: got vld=%b word=%h idx=%0d, want 1 0000 0",
               word_valid, word, word_index);
    end
    tick();
    tests++;
    if (word !== 16'h1111 || word_index !== 3'd1) begin
      fails++;
      $display("FAIL flush restart beat1: got word=%h idx=%0d, want 1111 1", word, word_index);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    do_load(c_b, 3'd0);
    tick(); tick(); tick(); tick();    // now on beat 4
    tests++;
    if (word !== 16'h4444 || word_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid pre: got word=%h vld=%b, want 4444 1", word, word_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if (word_valid !== 1'b0 || in_ready !== 1'b1 || word !== 16'h0000 ||
        word_index !== 3'd0 || last !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got vld=%b rdy=%b word=%h idx=%0d last=%b, want 0 1 0000 0 0",
               word_valid, in_ready, word, word_index, last);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [127:0] b;
      logic [2:0]   s;
      int e = 0, cyc = 0;
      b = {$urandom, $urandom, $urandom, $urandom};
      s = 3'($urandom_range(7));
      out_ready = 1'b1;
      do_load(b, s);
      while (e < 8 && cyc < 200) begin
        tests++;
        if (word_valid !== 1'b1 || word !== ref_word(b, s + e) ||
            word_index !== 3'((s + e) % 8) || last !== (e == 7)) begin
          fails++;
          $display("FAIL random burst %0d beat %0d: got vld=%b word=%h idx=%0d last=%b, want 1 %h %0d %b",
                   n, e, word_valid, word, word_index, last, ref_word(b, s + e), (s + e) % 8, (e == 7));
        end
        out_ready = 1'($urandom_range(1));
        tick();
        if (out_ready) e++;
        cyc++;
      end
      tests++;
      if (e != 8 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL random burst %0d end: got beats=%0d rdy=%b, want 8 1", n, e, in_ready);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; block = '0; start_index = 3'd0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_aligned();
    tick();
    test_wrap();
    tick();
    test_backpressure();
    tick();
    test_load_busy();
    tick();
    test_flush();
    tick();
    test_reset_mid();
    tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_block_word_streamer
`default_nettype wire

// File: doc/block_word_streamer.md
# block_word_streamer

Read-direction counterpart of the cache's word-into-line merge path. Accepts one 128-bit `lc3b_block` (a cache line or a physical-memory fill) and streams it out as eight 16-bit `lc3b_word` beats over a valid/ready handshake. The stream is critical-word-first: it starts at a requested word index and wraps modulo 8. It sits between the cache datapath and any word-wide consumer, such as the CPU return path or a 16-bit writeback bus.

## Interface
- Parameters: none. Geometry is fixed by `lc3b_block` (128 b), `lc3b_word` (16 b) and `lc3b_index` (3 b).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `load` in 1: request to capture `block`/`start_index`; honoured only when `in_ready`=1.
- `block` in 128 (`lc3b_block`): line to stream; word i = `block[16*i+15 : 16*i]`.
- `start_index` in 3 (`lc3b_index`): first word emitted.
- `flush` in 1: abort current burst.
- `out_ready` in 1: consumer accepts the current beat.
- `in_ready` out 1: block idle, can accept `load`.
- `word_valid` out 1: `word` is valid.
- `word` out 16 (`lc3b_word`): current beat.
- `word_index` out 3 (`lc3b_index`): line position of `word`.
- `last` out 1: current beat is the 8th of the burst.

## Operation
- Two states: IDLE and STREAM.
- IDLE:
  - `in_ready`=1, `word_valid`=0.
  - `load`=1 registers `block` into the line register, `start_index` into `idx`, clears `count` to 0, and moves to STREAM.
- STREAM:
  - `in_ready`=0, `word_valid`=1, `word` = line register word at `idx`, `word_index`=`idx`, `last`=(`count`==7).
  - A transfer occurs when `word_valid`&&`out_ready`. On a transfer, `idx` ← `idx`+1 (3-bit wrap, 7→0) and `count` ← `count`+1.
  - A transfer with `last`=1 returns to IDLE.
- Backpressure: while `out_ready`=0, `word`, `word_index` and `last` hold unchanged.
- `load` while in STREAM is ignored; the line register is not overwritten.
- `flush`=1 in STREAM forces IDLE on the next edge. It has priority over a same-cycle transfer, and that beat counts as not delivered. `flush` in IDLE has no effect. `flush` and `load` together in IDLE: `load` wins.
- Reset (`rst_n`=0 at an edge) forces IDLE from any state, including mid-burst. `in_ready`=1, `word_valid`=0, `last`=0, `word_index`=0, `word`=16'h0000. The line register clears to 0.
- All outputs are decoded from registered state only; there are no combinational input-to-output paths.

## Timing
- Load latency: `load` accepted at edge N gives the first beat valid in cycle N+1.
- Minimum burst: 8 cycles (N+1..N+8) with `out_ready` held high. `in_ready` returns to 1 in cycle N+9.
- Back-to-back bursts: a new `load` is accepted no earlier than cycle N+9. There is a one-cycle IDLE bubble between bursts by design.
- `out_ready` low for k cycles stretches the burst by exactly k cycles.

## Structure
- `lc3b_block`, `lc3b_word` and `lc3b_index` come from `lc3b_types`; no new shared constants.
- Add `lc3b_stream_state` (IDLE, STREAM) to `lc3b_types` so other streaming engines reuse it.
- One sub-module, `blockwordselect`: combinational 8:1 word mux (`lc3b_block`, `lc3b_index` → `lc3b_word`). It is the read-side inverse of the word merge.
- Top level holds the FSM, the `idx`/`count` counters and the line register.

## Test plan
Common stimulus: B = 128'h7777_6666_5555_4444_3333_2222_1111_0000.
- **Aligned burst**: `load` B with `start_index`=0, `out_ready`=1 → beats 0000,1111,…,7777 in cycles N+1..N+8. `word_index` runs 0..7. `last` only on 7777. `in_ready`=1 at N+9.
- **Critical-word-first wrap**: `start_index`=5 → beats 5555,6666,7777,0000,1111,2222,3333,4444. `word_index` wraps 7→0. `last` on 4444 with `word_index`=4.
- **Backpressure**: `start_index`=0, `out_ready`=0 for 3 cycles while on beat 2222 → `word`=2222 and `word_index`=2 held 3 cycles. Burst completes in 11 cycles total.
- **Load while busy**: second `load` with B'=all-ones during cycle N+3 → ignored. Remaining beats still 3333..7777.
- **Flush mid-burst**: `flush` together with a transfer of 3333 → IDLE next cycle, `word_valid`=0, `in_ready`=1. A following `load` of B at `start_index`=0 restarts at 0000.
- **Reset mid-burst**: `rst_n`=0 during beat 4444 → next cycle `word_valid`=0, `in_ready`=1, `word`=0000, `word_index`=0, `last`=0.
